// File: rtl/graycounter_pkg.sv
// Shared helpers for the gray counter family: code conversion at up to 32 bits.
// Narrower users zero-extend their operand and truncate the result.
package graycounter_pkg;

  localparam int MAX_WIDTH = 32;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper gray bits decode to zero, so truncation stays exact.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/graycounter_param.sv
// WIDTH-bit up/down counter with registered binary and gray outputs,
// synchronous load, wrap-or-saturate limit handling and a terminal-count pulse.
module graycounter_param
  import graycounter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] valuegray,
  output logic             tc
);

  localparam logic [WIDTH-1:0] VMAX = '1;
  localparam logic [WIDTH-1:0] VMIN = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST  = WIDTH'(RESET_VAL);
  localparam bit               SAT  = (SATURATE != 0);

  logic [WIDTH-1:0] nxt;
  logic             nxt_tc;

  // In wrap mode tc marks the wrapped result; in saturate mode it marks
  // reaching the limit and every attempt to push past it.
  always_comb begin
    nxt    = value;
    nxt_tc = 1'b0;
    if (en) begin
      if (up) begin
        if (value == VMAX) begin
          nxt    = SAT ? value : VMIN;
          nxt_tc = 1'b1;
        end else begin
          nxt    = value + ONE;
          nxt_tc = SAT && (nxt == VMAX);
        end
      end else begin
        if (value == VMIN) begin
          nxt    = SAT ? value : VMAX;
          nxt_tc = 1'b1;
        end else begin
          nxt    = value - ONE;
          nxt_tc = SAT && (nxt == VMIN);
        end
      end
    end
  end

  // Gray is derived from the next binary value so both registers move together.
  always_ff @(posedge clk) begin
    if (reset) begin
      value     <= RST;
      valuegray <= WIDTH'(bin2gray(MAX_WIDTH'(RST)));
      tc        <= 1'b0;
    end else if (load) begin
      value     <= load_val;
      valuegray <= WIDTH'(bin2gray(MAX_WIDTH'(load_val)));
      tc        <= 1'b0;
    end else begin
      value     <= nxt;
      valuegray <= WIDTH'(bin2gray(MAX_WIDTH'(nxt)));
      tc        <= nxt_tc;
    end
  end

endmodule

// File: tb/tb_graycounter_param.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share stimulus;
// the driver queues expected outputs, the monitor compares after each edge.
module tb_graycounter_param;
  import graycounter_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0, en = 1'b0, up = 1'b1, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] vw, gw, vs, gs;
  logic       tw, ts;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    bit         cw;
    logic [7:0] ew;
    logic       etw;
    bit         cs;
    logic [7:0] es;
    logic       ets;
    bit         ob;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  graycounter_param #(.WIDTH(8), .SATURATE(0), .RESET_VAL(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .value(vw), .valuegray(gw), .tc(tw));

  graycounter_param #(.WIDTH(8), .SATURATE(1), .RESET_VAL(8'h0A)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .value(vs), .valuegray(gs), .tc(ts));

  function automatic logic [7:0] g8(input logic [7:0] b);
    return b ^ {1'b0, b[7:1]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drive(input bit r, input bit l, input logic [7:0] lv, input bit e, input bit u,
                       input bit cw, input logic [7:0] ew, input logic etw,
                       input bit cs, input logic [7:0] es, input logic ets,
                       input string nm, input bit ob);
    exp_t x;
    @(negedge clk);
    reset = r; load = l; load_val = lv; en = e; up = u;
    x.nm = nm; x.cw = cw; x.ew = ew; x.etw = etw;
    x.cs = cs; x.es = es; x.ets = ets; x.ob = ob;
    q.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t x;
    logic [7:0] prev_gw;
    prev_gw = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        if (x.cw) begin
          chk({x.nm, " wrap value"}, 32'(vw), 32'(x.ew));
          chk({x.nm, " wrap gray"}, 32'(gw), 32'(g8(x.ew)));
          chk({x.nm, " wrap tc"}, 32'(tw), 32'(x.etw));
        end
        if (x.cs) begin
          chk({x.nm, " sat value"}, 32'(vs), 32'(x.es));
          chk({x.nm, " sat gray"}, 32'(gs), 32'(g8(x.es)));
          chk({x.nm, " sat tc"}, 32'(ts), 32'(x.ets));
        end
        if (x.ob) begin
          chk({x.nm, " gray bits flipped"}, 32'($countones(gw ^ prev_gw)), 32'd1);
          chk({x.nm, " gray2bin"}, gray2bin(32'(gw)), 32'(x.ew));
        end
      end
      prev_gw = gw;
    end
  end

  // Driver
  initial begin
    drive(1,0,8'h00,0,1, 1,8'h00,0, 1,8'h0A,0, "reset", 0);
    drive(1,0,8'h00,0,1, 1,8'h00,0, 1,8'h0A,0, "reset2", 0);

    for (int i = 1; i <= 256; i++)
      drive(0,0,8'h00,1,1, 1,8'(i),(i == 256), 0,8'h00,0, "sweep", 1);

    drive(0,1,8'hFE,0,1, 1,8'hFE,0, 1,8'hFE,0, "ld_fe", 0);
    drive(0,0,8'h00,1,1, 1,8'hFF,0, 0,8'h00,0, "wrapup1", 1);
    drive(0,0,8'h00,1,1, 1,8'h00,1, 0,8'h00,0, "wrapup2", 1);
    drive(0,0,8'h00,1,1, 1,8'h01,0, 0,8'h00,0, "wrapup3", 1);

    drive(0,1,8'h01,0,0, 1,8'h01,0, 1,8'h01,0, "ld_01", 0);
    drive(0,0,8'h00,1,0, 1,8'h00,0, 0,8'h00,0, "wrapdn1", 1);
    drive(0,0,8'h00,1,0, 1,8'hFF,1, 0,8'h00,0, "wrapdn2", 1);
    drive(0,0,8'h00,1,0, 1,8'hFE,0, 0,8'h00,0, "wrapdn3", 1);

    drive(0,1,8'hFD,0,1, 0,8'h00,0, 1,8'hFD,0, "ld_fd", 0);
    drive(0,0,8'h00,1,1, 0,8'h00,0, 1,8'hFE,0, "satup1", 0);
    drive(0,0,8'h00,1,1, 0,8'h00,0, 1,8'hFF,1, "satup2", 0);
    drive(0,0,8'h00,1,1, 0,8'h00,0, 1,8'hFF,1, "satup3", 0);
    drive(0,0,8'h00,1,1, 0,8'h00,0, 1,8'hFF,1, "satup4", 0);
    drive(0,0,8'h00,1,1, 0,8'h00,0, 1,8'hFF,1, "satup5", 0);
    drive(0,0,8'h00,0,1, 0,8'h00,0, 1,8'hFF,0, "sathold", 0);

    drive(0,1,8'h02,0,0, 0,8'h00,0, 1,8'h02,0, "ld_02", 0);
    drive(0,0,8'h00,1,0, 0,8'h00,0, 1,8'h01,0, "satdn1", 0);
    drive(0,0,8'h00,1,0, 0,8'h00,0, 1,8'h00,1, "satdn2", 0);
    drive(0,0,8'h00,1,0, 0,8'h00,0, 1,8'h00,1, "satdn3", 0);
    drive(0,0,8'h00,1,1, 0,8'h00,0, 1,8'h01,0, "satdn_up", 0);

    drive(1,1,8'h55,1,1, 1,8'h00,0, 1,8'h0A,0, "rst_over_load", 0);
    drive(0,1,8'h55,1,1, 1,8'h55,0, 1,8'h55,0, "load_over_en", 0);

    drive(0,1,8'h10,0,1, 1,8'h10,0, 1,8'h10,0, "ld_10", 0);
    for (int i = 0; i < 10; i++)
      drive(0,0,8'hAA,0,(i % 2 == 0), 1,8'h10,0, 1,8'h10,0, "hold", 0);
    for (int i = 0; i < 6; i++)
      drive(0,0,8'h00,1,(i % 2 == 0), 1,((i % 2 == 0) ? 8'h11 : 8'h10),0,
            1,((i % 2 == 0) ? 8'h11 : 8'h10),0, "dirflip", 1);

    drive(1,0,8'h00,1,1, 1,8'h00,0, 1,8'h0A,0, "rst_midcount", 0);
    drive(0,0,8'h00,0,1, 1,8'h00,0, 1,8'h0A,0, "post_rst", 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
